mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/mem_ctrl_array.sv | 49 ++++
 rtl/mem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizing helpers for the word-addressed memory controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_ctrl_pkg;

  // Controller FSM: IDLE accepts requests, WAIT burns the programmed wait cycles.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_ctrl_state_t;

  // Wait-cycle counter width; covers LATENCY values 0..15.
  localparam int CNT_W = 4;

  // Byte-offset bits dropped from the byte address to get a word address.
  function automatic int off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Word-index bits needed to address the array.
  function automatic int idx_bits(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/mem_ctrl_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x DATA_WIDTH, one read or write per cycle.
// Latency: read data registered, valid the cycle after i_re.
// Backpressure: none; accepts an access every cycle.
//
// Ports:
//   i_clk    clock
//   i_q_clr  synchronous clear of the read-data register (wins over i_re)
//   i_we     write strobe: array[i_idx] <= i_wdata
//   i_re     read strobe: o_rdata <= array[i_idx]
//   i_idx    word index
//   i_wdata  write data
//   o_rdata  registered read data; holds until the next read or clear
module mem_ctrl_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_q_clr,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_q;

  // Storage is deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Output register with its own synchronous clear, matching the block RAM
  // output-register reset, so the read port can be forced to zero.
  always_ff @(posedge i_clk) begin
    if (i_q_clr) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/mem_ctrl.sv
// Word-addressed memory controller terminating the Mem* request/ready interface.
// Latency: LATENCY wait cycles (MemReady low) per access; read data valid when MemReady rises.
// Backpressure: MemReady low while busy; Mem* inputs are ignored until it returns high.
//
// Ports:
//   HCLK      clock, all state updates on the rising edge
//   HRESET    synchronous active-high reset, priority over MemReq
//   MemAddr   byte address; word index = MemAddr[OFF+IDX-1:OFF]
//   MemWrite  1 = write, 0 = read; qualified by MemReq
//   MemWData  write data
//   MemReq    request strobe, sampled only while MemReady = 1
//   MemRData  registered read data; holds until the next read completes
//   MemReady  registered; high = idle / accepting / access complete
//   MemErr    (only with MEM_CTRL_ERR_EN) registered out-of-range flag
//
// Build option MEM_CTRL_ERR_EN: flag addresses above the array instead of aliasing.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] MemWData,
  input  logic                  MemReq,
  output logic [DATA_WIDTH-1:0] MemRData,
`ifdef MEM_CTRL_ERR_EN
  output logic                  MemReady,
  output logic                  MemErr
`else
  output logic                  MemReady
`endif
);

  localparam int OFF = off_bits(DATA_WIDTH);
  localparam int IDX = idx_bits(DEPTH_WORDS);
  localparam int HI  = OFF + IDX;
  localparam bit LAT0 = (LATENCY == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  mem_ctrl_state_t       r_state;
  mem_ctrl_state_t       w_state_nxt;
  logic                  r_ready;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX-1:0]        r_idx;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_oor;

  logic [IDX-1:0]        w_idx_in;
  logic                  w_oor_in;
  logic                  w_accept;
  logic                  w_acc_en;
  logic                  w_acc_we;
  logic [IDX-1:0]        w_acc_idx;
  logic [DATA_WIDTH-1:0] w_acc_wdata;
  logic                  w_acc_oor;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic                  w_q_clr;
  logic                  w_unused_addr;

  assign w_idx_in = MemAddr[HI-1:OFF];
  // Byte-offset and (in the aliasing build) upper address bits carry no meaning here.
  assign w_unused_addr = ^MemAddr;

`ifdef MEM_CTRL_ERR_EN
  generate
    if (ADDR_WIDTH > HI) begin : g_oor
      assign w_oor_in = |MemAddr[ADDR_WIDTH-1:HI];
    end else begin : g_no_oor
      assign w_oor_in = 1'b0;
    end
  endgenerate
`else
  assign w_oor_in = 1'b0;
`endif

  // Next state and the access issued to the array this cycle. A LATENCY of 0
  // issues straight from the inputs; otherwise the access comes from the latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_acc_en    = 1'b0;
    w_acc_we    = r_we;
    w_acc_idx   = r_idx;
    w_acc_wdata = r_wdata;
    w_acc_oor   = r_oor;
    case (r_state)
      IDLE: begin
        if (MemReq) begin
          w_accept = 1'b1;
          if (LAT0) begin
            w_acc_en    = 1'b1;
            w_acc_we    = MemWrite;
            w_acc_idx   = w_idx_in;
            w_acc_wdata = MemWData;
            w_acc_oor   = w_oor_in;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_acc_en    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Reset discards both new and pending accesses; a pending write never lands.
    if (HRESET) begin
      w_state_nxt = IDLE;
      w_accept    = 1'b0;
      w_acc_en    = 1'b0;
    end
  end

  // Out-of-range writes are dropped; out-of-range reads zero the read register.
  assign w_ram_we = w_acc_en & w_acc_we & ~w_acc_oor;
  assign w_ram_re = w_acc_en & ~w_acc_we;
  assign w_q_clr  = HRESET | (w_ram_re & w_acc_oor);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_ready <= 1'b1;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_oor   <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == IDLE);
      if (w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_idx   <= w_idx_in;
        r_we    <= MemWrite;
        r_wdata <= MemWData;
        r_oor   <= w_oor_in;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

`ifdef MEM_CTRL_ERR_EN
  logic r_err;

  // Set at completion of an out-of-range access; cleared by the next acceptance.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_err <= 1'b0;
    end else if (w_accept || w_acc_en) begin
      r_err <= w_acc_en & w_acc_oor;
    end
  end

  assign MemErr = r_err;
`endif

  mem_ctrl_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .i_clk   (HCLK),
    .i_q_clr (w_q_clr),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_idx   (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (MemRData)
  );

  assign MemReady = r_ready;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: LATENCY=2 instance plus a LATENCY=0 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] addr0, wdata0, rdata0;
  logic        we0, req0, rdy0;
  logic [31:0] addr1, wdata1, rdata1;
  logic        we1, req1, rdy1;
`ifdef MEM_CTRL_ERR_EN
  logic        err0, err1;
`endif

  int checks = 0;
  int errors = 0;

  mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(16), .LATENCY(2)) u_dut (
    .HCLK(clk), .HRESET(rst), .MemAddr(addr0), .MemWrite(we0), .MemWData(wdata0),
    .MemReq(req0), .MemRData(rdata0),
`ifdef MEM_CTRL_ERR_EN
    .MemReady(rdy0), .MemErr(err0)
`else
    .MemReady(rdy0)
`endif
  );

  mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(16), .LATENCY(0)) u_dut_l0 (
    .HCLK(clk), .HRESET(rst), .MemAddr(addr1), .MemWrite(we1), .MemWData(wdata1),
    .MemReq(req1), .MemRData(rdata1),
`ifdef MEM_CTRL_ERR_EN
    .MemReady(rdy1), .MemErr(err1)
`else
    .MemReady(rdy1)
`endif
  );

  // One access on the LATENCY=2 instance; returns cycles with MemReady low and
  // the read data / error flag seen in the cycle MemReady returns high.
  task automatic acc0(input bit we, input logic [31:0] a, input logic [31:0] d,
                      output int lo, output logic [31:0] rd, output bit er);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    @(posedge clk); #1;
    req0 = 1'b0;
    lo = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy0) break;
      lo++;
    end
    rd = rdata0;
`ifdef MEM_CTRL_ERR_EN
    er = err0;
`else
    er = 1'b0;
`endif
  endtask

  task automatic test_reset();
    int lo; logic [31:0] rd; bit er;
    acc0(1'b1, 32'h0, 32'h0BAD_0BAD, lo, rd, er);
    acc0(1'b0, 32'h0, 32'h0, lo, rd, er);
    checks++;
    if (rd !== 32'h0BAD_0BAD) begin
      errors++; $display("FAIL reset_pre_read got=%h exp=%h", rd, 32'h0BAD_0BAD);
    end
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", rdy0);
    end
    checks++;
    if (rdata0 !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=0", rdata0);
    end
    acc0(1'b0, 32'h0, 32'h0, lo, rd, er);
    checks++;
    if (rd !== 32'h0BAD_0BAD) begin
      errors++; $display("FAIL reset_no_write got=%h exp=%h", rd, 32'h0BAD_0BAD);
    end
  endtask

  task automatic test_write_read();
    int lo; logic [31:0] rd; bit er;
    acc0(1'b1, 32'h10, 32'hDEAD_BEEF, lo, rd, er);
    checks++;
    if (lo !== 2) begin
      errors++; $display("FAIL wr_wait_cycles got=%0d exp=2", lo);
    end
    acc0(1'b0, 32'h10, 32'h0, lo, rd, er);
    checks++;
    if (lo !== 2) begin
      errors++; $display("FAIL rd_wait_cycles got=%0d exp=2", lo);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_data got=%h exp=%h", rd, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_busy_ignore();
    int lo; logic [31:0] rd; bit er;
    acc0(1'b1, 32'h18, 32'h3333_3333, lo, rd, er);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h14; wdata0 = 32'h1111_1111;
    @(posedge clk); #1;
    addr0 = 32'h18; wdata0 = 32'h2222_2222;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++; $display("FAIL busy_ready_low got=%b exp=0", rdy0);
    end
    @(posedge clk);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL busy_not_accepted got=%b exp=1", rdy0);
    end
    acc0(1'b0, 32'h18, 32'h0, lo, rd, er);
    checks++;
    if (rd !== 32'h3333_3333) begin
      errors++; $display("FAIL busy_0x18_kept got=%h exp=%h", rd, 32'h3333_3333);
    end
    acc0(1'b0, 32'h14, 32'h0, lo, rd, er);
    checks++;
    if (rd !== 32'h1111_1111) begin
      errors++; $display("FAIL busy_0x14 got=%h exp=%h", rd, 32'h1111_1111);
    end
  endtask

  task automatic test_alias();
    int lo; logic [31:0] rd; bit er;
    acc0(1'b1, 32'h40, 32'hA5A5_A5A5, lo, rd, er);
    checks++;
    if (lo !== 2) begin
      errors++; $display("FAIL alias_wr_wait got=%0d exp=2", lo);
    end
`ifdef MEM_CTRL_ERR_EN
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL err_on_write got=%b exp=1", er);
    end
    acc0(1'b0, 32'h40, 32'h0, lo, rd, er);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL err_read_zero got=%h exp=0", rd);
    end
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL err_on_read got=%b exp=1", er);
    end
    acc0(1'b0, 32'h0, 32'h0, lo, rd, er);
    checks++;
    if (rd !== 32'h0BAD_0BAD) begin
      errors++; $display("FAIL err_write_dropped got=%h exp=%h", rd, 32'h0BAD_0BAD);
    end
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL err_cleared got=%b exp=0", er);
    end
`else
    acc0(1'b0, 32'h0, 32'h0, lo, rd, er);
    checks++;
    if (rd !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL alias_read got=%h exp=%h", rd, 32'hA5A5_A5A5);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    int lo; logic [31:0] rd; bit er;
    acc0(1'b1, 32'h8, 32'hCAFE_F00D, lo, rd, er);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h1234_5678;
    @(posedge clk); #1;
    req0 = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL midrst_ready got=%b exp=1", rdy0);
    end
    acc0(1'b0, 32'h8, 32'h0, lo, rd, er);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL midrst_no_commit got=%h exp=%h", rd, 32'hCAFE_F00D);
    end
  endtask

  task automatic test_back_to_back_lat0();
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4; wdata1 = 32'h55;
    @(posedge clk); #1;
    we1 = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy1 !== 1'b1) begin
      errors++; $display("FAIL lat0_ready_after_wr got=%b exp=1", rdy1);
    end
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++; $display("FAIL lat0_rdata_after_wr got=%h exp=0", rdata1);
    end
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata1 !== 32'h55) begin
      errors++; $display("FAIL lat0_read got=%h exp=%h", rdata1, 32'h55);
    end
    checks++;
    if (rdy1 !== 1'b1) begin
      errors++; $display("FAIL lat0_ready_after_rd got=%b exp=1", rdy1);
    end
`ifdef MEM_CTRL_ERR_EN
    checks++;
    if (err1 !== 1'b0) begin
      errors++; $display("FAIL lat0_err got=%b exp=0", err1);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    test_reset();
    test_write_read();
    test_busy_ignore();
    test_alias();
    test_reset_mid_write();
    test_back_to_back_lat0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
